// File: rtl/dma_channel_scheduler.sv
// dma_channel_scheduler: round-robin, two-class priority arbiter that grants the
// DMA transfer datapath to one channel at a time, with an optional beat quantum.
`default_nettype none

module dma_channel_scheduler #(
    parameter int N_CHANNELS = 4,
    parameter int CHANNEL_W  = $clog2(N_CHANNELS),
    parameter int QUANTUM_W  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [N_CHANNELS-1:0] req_i,
    input  logic [N_CHANNELS-1:0] hi_prio_i,
    input  logic [QUANTUM_W-1:0]  quantum_i,
    input  logic                  beat_i,
    input  logic                  last_i,
    output logic [N_CHANNELS-1:0] grant_o,
    output logic                  grant_valid_o,
    output logic [CHANNEL_W-1:0]  grant_id_o,
    output logic                  quantum_exp_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [N_CHANNELS-1:0] grant_q, grant_d;
    logic [CHANNEL_W-1:0]  grant_id_q, grant_id_d;
    logic [CHANNEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [QUANTUM_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [QUANTUM_W-1:0]  q_lat_q, q_lat_d;
    logic                  qexp_q, qexp_d;

    logic [N_CHANNELS-1:0] hi_req;
    logic [N_CHANNELS-1:0] cand;
    logic [CHANNEL_W-1:0]  win_id;
    logic [CHANNEL_W-1:0]  rr_next;
    logic                  quantum_hit;

    // First set bit of v scanning upward from ptr with wrap-around.
    function automatic logic [CHANNEL_W-1:0] pick_rr(
        input logic [N_CHANNELS-1:0] v,
        input logic [CHANNEL_W-1:0]  ptr
    );
        logic [CHANNEL_W-1:0] res;
        logic [CHANNEL_W-1:0] idx_w;
        int                   idx;
        res = '0;
        for (int k = N_CHANNELS - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_CHANNELS) begin
                idx = idx - N_CHANNELS;
            end
            idx_w = idx[CHANNEL_W-1:0];
            if (v[idx_w]) begin
                res = idx_w;
            end
        end
        return res;
    endfunction

    assign hi_req      = req_i & hi_prio_i;
    assign cand        = (|hi_req) ? hi_req : req_i;
    assign win_id      = pick_rr(cand, rr_ptr_q);
    assign rr_next     = (grant_id_q == CHANNEL_W'(N_CHANNELS - 1)) ? '0
                                                                     : grant_id_q + CHANNEL_W'(1);
    assign quantum_hit = (q_lat_q != '0) && beat_i && (beat_cnt_q == q_lat_q - QUANTUM_W'(1));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        q_lat_d    = q_lat_q;
        qexp_d     = 1'b0;
        unique case (state_q)
            // RELEASE is the single dead cycle; it arbitrates with the already
            // advanced pointer so back-to-back grants are one zero cycle apart.
            ST_IDLE, ST_RELEASE: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                grant_id_d = '0;
                if (|req_i) begin
                    state_d    = ST_GRANT;
                    grant_d    = {{(N_CHANNELS-1){1'b0}}, 1'b1} << win_id;
                    grant_id_d = win_id;
                    q_lat_d    = quantum_i;
                    beat_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (beat_i && (beat_cnt_q != '1)) begin
                    beat_cnt_d = beat_cnt_q + QUANTUM_W'(1);
                end
                if (last_i || quantum_hit || !req_i[grant_id_q]) begin
                    state_d    = ST_RELEASE;
                    grant_d    = '0;
                    grant_id_d = '0;
                    rr_ptr_d   = rr_next;
                    qexp_d     = quantum_hit && !last_i;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                grant_d    = '0;
                grant_id_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            q_lat_q    <= '0;
            qexp_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            q_lat_q    <= q_lat_d;
            qexp_q     <= qexp_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_valid_o = |grant_q;
    assign grant_id_o    = grant_id_q;
    assign quantum_exp_o = qexp_q;

endmodule

`default_nettype wire

// File: tb/tb_dma_channel_scheduler.sv
// Self-checking bench for dma_channel_scheduler: chained arbitration vectors with a
// scoreboard of expected grants, plus abort, idle-beat and reset-mid-grant sequences.
`default_nettype none

module tb_dma_channel_scheduler;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] hi;
    logic [7:0] quantum;
    logic       beat;
    logic       last;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       qexp;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] hi;
        logic [7:0] q;
        int         beats;
        bit         use_last;
        int         exp_id;
        bit         exp_qexp;
    } vec_t;

    typedef struct {
        int id;
        bit qexp;
    } exp_t;

    vec_t vecs[16];
    exp_t sb[$];

    dma_channel_scheduler #(
        .N_CHANNELS(4),
        .CHANNEL_W (2),
        .QUANTUM_W (8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .hi_prio_i    (hi),
        .quantum_i    (quantum),
        .beat_i       (beat),
        .last_i       (last),
        .grant_o      (grant),
        .grant_valid_o(grant_valid),
        .grant_id_o   (grant_id),
        .quantum_exp_o(qexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int         n;
        exp_t       e;
        logic [3:0] eg;
        req     = v.req;
        hi      = v.hi;
        quantum = v.q;
        sb.push_back('{v.exp_id, v.exp_qexp});
        n = 0;
        do begin
            step();
            n++;
        end while (!grant_valid && n < 4);
        check("grant_latency", 32'(n), 32'd1);
        e  = sb.pop_front();
        eg = 4'b0001 << e.id;
        check("grant_id", 32'(grant_id), 32'(e.id));
        check("grant_onehot", 32'(grant), 32'(eg));
        check("qexp_during_grant", 32'(qexp), 32'd0);
        if (v.beats == 0) begin
            last = v.use_last;
            step();
        end else begin
            for (int i = 0; i < v.beats; i++) begin
                beat = 1'b1;
                last = v.use_last && (i == v.beats - 1);
                step();
                if (i < v.beats - 1) begin
                    check("grant_hold", 32'(grant), 32'(eg));
                end
            end
        end
        beat = 1'b0;
        last = 1'b0;
        check("release_grant", 32'(grant), 32'd0);
        check("release_id", 32'(grant_id), 32'd0);
        check("release_qexp", 32'(qexp), 32'(e.qexp));
    endtask

    initial begin
        // req, hi, quantum, beats, last, expected id, expected quantum pulse
        vecs[0]  = '{4'b0100, 4'b0000, 8'd0, 0,   1'b1, 2, 1'b0};
        vecs[1]  = '{4'b1001, 4'b0000, 8'd0, 0,   1'b1, 3, 1'b0};
        vecs[2]  = '{4'b1111, 4'b0000, 8'd0, 2,   1'b1, 0, 1'b0};
        vecs[3]  = '{4'b1111, 4'b0000, 8'd0, 2,   1'b1, 1, 1'b0};
        vecs[4]  = '{4'b1111, 4'b0000, 8'd0, 2,   1'b1, 2, 1'b0};
        vecs[5]  = '{4'b1111, 4'b0000, 8'd0, 2,   1'b1, 3, 1'b0};
        vecs[6]  = '{4'b1111, 4'b0000, 8'd0, 2,   1'b1, 0, 1'b0};
        vecs[7]  = '{4'b1011, 4'b1000, 8'd0, 1,   1'b1, 3, 1'b0};
        vecs[8]  = '{4'b0011, 4'b1000, 8'd0, 1,   1'b1, 0, 1'b0};
        vecs[9]  = '{4'b0010, 4'b0000, 8'd0, 1,   1'b1, 1, 1'b0};
        vecs[10] = '{4'b0010, 4'b0000, 8'd4, 4,   1'b0, 1, 1'b1};
        vecs[11] = '{4'b0011, 4'b0000, 8'd4, 1,   1'b1, 0, 1'b0};
        vecs[12] = '{4'b0010, 4'b0000, 8'd3, 3,   1'b1, 1, 1'b0};
        vecs[13] = '{4'b0100, 4'b0000, 8'd0, 300, 1'b1, 2, 1'b0};
        vecs[14] = '{4'b0111, 4'b0011, 8'd0, 1,   1'b1, 0, 1'b0};
        vecs[15] = '{4'b1000, 4'b0000, 8'd1, 1,   1'b0, 3, 1'b1};

        rst_n   = 1'b0;
        req     = '0;
        hi      = '0;
        quantum = '0;
        beat    = 1'b0;
        last    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_valid", 32'(grant_valid), 32'd0);
        check("reset_id", 32'(grant_id), 32'd0);
        check("reset_qexp", 32'(qexp), 32'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 16; k++) begin
            run_txn(vecs[k]);
        end
        req = '0;
        step();
        check("idle_after_vectors", 32'(grant_valid), 32'd0);

        // Quantum latched at grant; a mid-grant change must not shorten it, then abort.
        req     = 4'b0100;
        quantum = 8'd2;
        step();
        check("abort_grant_id", 32'(grant_id), 32'd2);
        quantum = 8'd1;
        beat    = 1'b1;
        step();
        check("quantum_latched_hold", 32'(grant), 32'b0100);
        beat = 1'b0;
        req  = '0;
        step();
        check("abort_release", 32'(grant), 32'd0);
        check("abort_no_qexp", 32'(qexp), 32'd0);
        step();

        // Beats and last while idle are ignored.
        beat = 1'b1;
        last = 1'b1;
        step();
        check("idle_beat_ignored", 32'(grant_valid), 32'd0);
        check("idle_qexp", 32'(qexp), 32'd0);
        beat    = 1'b0;
        last    = 1'b0;
        quantum = 8'd0;

        // Move rr_ptr to 1, start a grant, then reset mid-grant.
        req = 4'b0001;
        step();
        check("pre_reset_grant0", 32'(grant_id), 32'd0);
        req  = 4'b0100;
        last = 1'b1;
        step();
        last = 1'b0;
        check("pre_reset_release", 32'(grant), 32'd0);
        step();
        check("pre_reset_grant2", 32'(grant), 32'b0100);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_grant", 32'(grant), 32'd0);
        check("async_reset_valid", 32'(grant_valid), 32'd0);
        check("async_reset_id", 32'(grant_id), 32'd0);
        check("async_reset_qexp", 32'(qexp), 32'd0);
        req = 4'b0011;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("post_reset_rr_ptr0", 32'(grant_id), 32'd0);
        check("post_reset_onehot", 32'(grant), 32'b0001);
        req  = '0;
        last = 1'b1;
        step();
        last = 1'b0;
        check("post_reset_release", 32'(grant), 32'd0);
        check("post_reset_qexp", 32'(qexp), 32'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dma_channel_scheduler.md
Name: dma_channel_scheduler

Overview:
- Round-robin, two-level-priority channel scheduler for the DMA engine.
- Grants the shared transfer datapath to exactly one requesting channel at a time and holds the grant for the whole transfer.
- Forces release after a programmable beat quantum so one channel cannot starve the others.
- Sits between the per-channel request/config logic and the single DMA transfer engine.

Parameters:
- N_CHANNELS, 4: number of DMA channels (2..16).
- CHANNEL_W, $clog2(N_CHANNELS): channel index width.
- QUANTUM_W, 8: width of the beat quantum and the beat counter.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- req_i  input  N_CHANNELS  per-channel transfer request, level; held until the channel is served.
- hi_prio_i  input  N_CHANNELS  per-channel priority class; 1 = high.
- quantum_i  input  QUANTUM_W  max beats per grant; 0 means unlimited; sampled at grant.
- beat_i  input  1  engine moved one beat for the granted channel.
- last_i  input  1  engine finished the granted channel's transfer.
- grant_o  output  N_CHANNELS  one-hot grant, registered.
- grant_valid_o  output  1  OR of grant_o.
- grant_id_o  output  CHANNEL_W  index of the granted channel; 0 when no grant.
- quantum_exp_o  output  1  one-cycle pulse when a grant is revoked by quantum expiry.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: grant_o=0, grant_valid_o=0, grant_id_o=0, quantum_exp_o=0, rr_ptr=0, beat_cnt=0, state=IDLE.
- FSM states:
  - IDLE: grant_o=0. If any req_i is set, latch the winner, load q_lat=quantum_i, clear beat_cnt, go to GRANT. The grant appears one cycle after the request is sampled.
  - GRANT: grant_o is one-hot and stable. beat_i increments beat_cnt; beat_cnt saturates at all-ones.
  - RELEASE: grant_o=0 for exactly one cycle. Set rr_ptr = granted index + 1, modulo N_CHANNELS. Go to IDLE. Minimum gap between two grants is therefore one dead cycle.
- Winner selection in IDLE:
  - If any req_i & hi_prio_i bit is set, pick among those only; otherwise pick among all req_i.
  - Within the chosen set, pick the first set bit scanning upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ... N-1, 0, ...).
  - Both priority classes share the single rr_ptr.
- Leaving GRANT → RELEASE (any one of these, evaluated each cycle):
  - last_i=1.
  - q_lat≠0 and beat_i=1 and beat_cnt==q_lat-1 (the quantum-th beat). Pulse quantum_exp_o in the RELEASE cycle, unless last_i was also 1 in that cycle.
  - req_i[granted]=0 (channel aborted).
- Simultaneous events:
  - last_i together with the quantum-th beat: counts as normal completion, no quantum_exp_o.
  - beat_i/last_i while not in GRANT: ignored.
  - Changes to hi_prio_i or quantum_i during GRANT: no effect until the next arbitration.
- Quantum expiry: the channel keeps req_i high and re-competes. It is now lowest round-robin priority within its class.
- Reset mid-grant: outputs drop to reset values asynchronously. No RELEASE cycle and no pulse are produced.
- grant_o is never multi-hot, and never changes directly from one channel to another without a zero cycle.

Test Plan:
- Reset, then req_i=4'b0100 → grant_o=4'b0100, grant_id_o=2 one cycle later. Assert last_i → one zero cycle, rr_ptr=3.
- req_i=4'b1111 constant, all low priority, last_i after 2 beats each → grant order 0,1,2,3,0, each grant separated by one zero cycle.
- req_i=4'b1011, hi_prio_i=4'b1000 → channel 3 granted first. After it completes and drops req, then 0, then 1.
- quantum_i=4, req_i[1] held, beats every cycle, no last_i → grant drops after the 4th beat, quantum_exp_o=1 for one cycle. If req_i=4'b0011, the next grant is channel 0 only if it is after rr_ptr; with rr_ptr=2 the wrap order gives channel 0.
- quantum_i=0 → 300 beats with no revocation, beat_cnt saturates at 255, release only on last_i.
- Deassert rst_ni mid-GRANT → grant_o=0 the same cycle. After release, req_i=4'b0001 → grant to 0 with rr_ptr=0.
- Abort: req_i[2] falls during GRANT → RELEASE next cycle, quantum_exp_o stays 0.
